regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 75 +++++++
 rtl/regfile_scoreboard.sv | 78 +++++++
 tb/tb_regfile_scoreboard.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file with issue scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREAD  = 2;

  // The counter must hold the full depth (2**addr_w), so it needs one extra bit.
  function automatic int busy_cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending producer, grants
// reservations and keeps a running count of busy registers.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREAD*ADDR_W-1:0]           rd_addr,
  output logic [NREAD-1:0]                  rd_ready,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic                              rsv_en,
  input  logic [ADDR_W-1:0]                 rsv_addr,
  output logic                              rsv_ok,
  output logic [busy_cnt_width(ADDR_W)-1:0] busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = busy_cnt_width(ADDR_W);

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsv_hit_wr;
  logic              rsv_zero;
  logic              rsv_set;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [ADDR_W-1:0] rd_a;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch; this block uses blocking '='.
  always_comb begin
    rsv_hit_wr = wr_en && (wr_addr == rsv_addr);
    rsv_ok     = rsv_en && (!busy_q[rsv_addr] || rsv_hit_wr);
    rsv_zero   = (ZERO_REG != 0) && (rsv_addr == '0);
    rsv_set    = rsv_ok && !rsv_zero;

    // Write clears first, reservation sets last: a same-cycle collision stays busy.
    busy_d = busy_q;
    if (wr_en)   busy_d[wr_addr]  = 1'b0;
    if (rsv_set) busy_d[rsv_addr] = 1'b1;

    cnt_inc = rsv_set && !busy_q[rsv_addr];
    cnt_dec = wr_en && busy_q[wr_addr] && !busy_d[wr_addr];
    cnt_d   = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  always_comb begin
    rd_ready = '0;
    rd_a     = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_a        = rd_addr[i*ADDR_W +: ADDR_W];
      rd_ready[i] = !busy_q[rd_a] || (wr_en && (wr_addr == rd_a));
    end
  end

  // NOTE: state flops use non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-through bypass and a busy-bit
// scoreboard for in-order issue / out-of-order writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NREAD    = DEF_NREAD,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NREAD*ADDR_W-1:0]           rd_addr,
  output logic [NREAD*DATA_W-1:0]           rd_data,
  output logic [NREAD-1:0]                  rd_ready,
  input  logic                              wr_en,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              rsv_en,
  input  logic [ADDR_W-1:0]                 rsv_addr,
  output logic                              rsv_ok,
  output logic [busy_cnt_width(ADDR_W)-1:0] busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_zero;
  logic [ADDR_W-1:0] rd_a;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en && !wr_zero) mem_d[wr_addr] = wr_data;
  end

  // NOTE: the array is reset on purpose: every register must read as zero
  // after reset, so this stays flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Zero register wins over bypass, bypass wins over stored contents.
  always_comb begin
    rd_data = '0;
    rd_a    = '0;
    for (int i = 0; i < NREAD; i++) begin
      rd_a = rd_addr[i*ADDR_W +: ADDR_W];
      if ((ZERO_REG != 0) && (rd_a == '0))
        rd_data[i*DATA_W +: DATA_W] = '0;
      else if (wr_en && (wr_addr == rd_a))
        rd_data[i*DATA_W +: DATA_W] = wr_data;
      else
        rd_data[i*DATA_W +: DATA_W] = mem_q[rd_a];
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NREAD    (NREAD),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a vector table for the basic
// read/bypass/reserve behaviour plus hand sequences for full-board and reset.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_cnt (busy_cnt)
  );

  typedef struct {
    bit        we;
    bit [4:0]  wa;
    bit [31:0] wd;
    bit        re;
    bit [4:0]  ra;
    bit [4:0]  a0;
    bit [4:0]  a1;
    bit [31:0] e0;
    bit [31:0] e1;
    bit [1:0]  erdy;
    bit        eok;
    bit [5:0]  ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    // we wa    wd            re ra  a0  a1  e0            e1            rdy   ok  cnt
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 0,  1,  32'h0,        32'h0,        2'b11, 0, 0});
    vecs.push_back(vec_t'{1, 5, 32'hDEADBEEF, 0, 0, 5,  1,  32'hDEADBEEF, 32'h0,        2'b11, 0, 0});
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 0, 0});
    vecs.push_back(vec_t'{1, 7, 32'h12345678, 0, 0, 1,  7,  32'h0,        32'h12345678, 2'b11, 0, 0});
    vecs.push_back(vec_t'{0, 0, 32'h0,        1, 3, 3,  7,  32'h0,        32'h12345678, 2'b11, 1, 0});
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 3,  7,  32'h0,        32'h12345678, 2'b10, 0, 1});
    vecs.push_back(vec_t'{1, 3, 32'hA5,       0, 0, 3,  3,  32'hA5,       32'hA5,       2'b11, 0, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 3,  0,  32'hA5,       32'h0,        2'b11, 0, 0});
    vecs.push_back(vec_t'{0, 0, 32'h0,        1, 4, 4,  0,  32'h0,        32'h0,        2'b11, 1, 0});
    vecs.push_back(vec_t'{0, 0, 32'h0,        1, 4, 4,  0,  32'h0,        32'h0,        2'b10, 0, 1});
    vecs.push_back(vec_t'{1, 4, 32'h1,        1, 4, 4,  4,  32'h1,        32'h1,        2'b11, 1, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 4,  0,  32'h1,        32'h0,        2'b10, 0, 1});
    vecs.push_back(vec_t'{1, 0, 32'hFFFFFFFF, 1, 0, 0,  4,  32'h0,        32'h1,        2'b01, 1, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 0,  4,  32'h0,        32'h1,        2'b01, 0, 1});
    vecs.push_back(vec_t'{1, 4, 32'h22,       0, 0, 4,  5,  32'h22,       32'hDEADBEEF, 2'b11, 0, 1});
    vecs.push_back(vec_t'{0, 0, 32'h0,        0, 0, 4,  0,  32'h22,       32'h0,        2'b11, 0, 0});

    idle();
    rd_addr = '0;
    rst_n   = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      wr_en    = vecs[i].we;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      rsv_en   = vecs[i].re;
      rsv_addr = vecs[i].ra;
      rd_addr  = {vecs[i].a1, vecs[i].a0};
      #1;
      check($sformatf("v%0d rd_data0", i), 64'(rd_data[31:0]),  64'(vecs[i].e0));
      check($sformatf("v%0d rd_data1", i), 64'(rd_data[63:32]), 64'(vecs[i].e1));
      check($sformatf("v%0d rd_ready", i), 64'(rd_ready),       64'(vecs[i].erdy));
      check($sformatf("v%0d rsv_ok", i),   64'(rsv_ok),         64'(vecs[i].eok));
      check($sformatf("v%0d busy_cnt", i), 64'(busy_cnt),       64'(vecs[i].ecnt));
      step();
    end

    // Full scoreboard: reserve r1..r31 back to back.
    idle();
    for (int i = 1; i < 32; i++) begin
      rsv_en   = 1'b1;
      rsv_addr = 5'(i);
      #1;
      check($sformatf("full rsv_ok r%0d", i), 64'(rsv_ok), 64'd1);
      step();
    end
    idle();
    rd_addr = {5'd0, 5'd5};
    #1;
    check("full busy_cnt", 64'(busy_cnt), 64'd31);
    check("full rd_ready r5/r0", 64'(rd_ready), 64'b10);
    rsv_en   = 1'b1;
    rsv_addr = 5'd5;
    #1;
    check("full waw rsv_ok", 64'(rsv_ok), 64'd0);
    step();
    idle();
    #1;
    check("full waw busy_cnt", 64'(busy_cnt), 64'd31);

    for (int i = 1; i < 32; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 32'h100 + 32'(i);
      step();
      idle();
      #1;
      check($sformatf("drain busy_cnt after r%0d", i), 64'(busy_cnt), 64'(31 - i));
    end
    rd_addr = {5'd31, 5'd17};
    #1;
    check("drain rd_data r17", 64'(rd_data[31:0]),  64'h111);
    check("drain rd_data r31", 64'(rd_data[63:32]), 64'h11F);
    check("drain rd_ready",    64'(rd_ready),       64'b11);

    // Reset mid-operation: pending reservation and same-cycle requests are dropped.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    step();
    idle();
    rd_addr = {5'd9, 5'd5};
    #1;
    check("pre-reset rd_data r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("pre-reset busy_cnt",   64'(busy_cnt),      64'd1);
    check("pre-reset rd_ready",   64'(rd_ready),      64'b01);
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h55AA55AA;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    step();
    rst_n = 1'b1;
    idle();
    #1;
    check("reset busy_cnt", 64'(busy_cnt), 64'd0);
    for (int i = 0; i < 32; i += 2) begin
      rd_addr = {5'(i + 1), 5'(i)};
      #1;
      check($sformatf("reset rd_data r%0d/r%0d", i, i + 1), rd_data, 64'h0);
      check($sformatf("reset rd_ready r%0d/r%0d", i, i + 1), 64'(rd_ready), 64'b11);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
